io_bank: RTL and testbench

IO_BANK -- requirements
Module: io_bank

---
 rtl/io_bank_if.sv | 22 ++
 rtl/io_bank.sv | 176 +++++++++++++++++
 tb/tb_io_bank.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/io_bank_if.sv
// Processor-side IO bus: address, write data, write strobe and combinational read data.
// The processor side is the master; io_bank is the slave.
interface io_bank_if;
    logic [31:0] IO_mem_addr;
    logic [31:0] IO_mem_wdata;
    logic        IO_mem_wr;
    logic [31:0] IO_mem_rdata;

    modport master (
        output IO_mem_addr,
        output IO_mem_wdata,
        output IO_mem_wr,
        input  IO_mem_rdata
    );

    modport slave (
        input  IO_mem_addr,
        input  IO_mem_wdata,
        input  IO_mem_wr,
        output IO_mem_rdata
    );
endinterface

// File: rtl/io_bank.sv
// Memory-mapped IO bank: LED register plus 8N1 UART TX with a small byte FIFO; reads are combinational.
// TXD goes low one edge after a write to an idle, empty FIFO; writes to a full FIFO are dropped and flag overflow.
module io_bank #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       resetn,
    io_bank_if.slave   bus,
    output logic [4:0] LEDS,
    output logic       TXD
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW-1:0] PTR_LAST  = AW'(FIFO_DEPTH - 1);
    localparam logic [3:0]    CNT_FULL  = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    tx_state_t      state, state_nx;
    logic [BW-1:0]  baud, baud_nx;
    logic [2:0]     bit_idx, bit_nx;
    logic [7:0]     shift, shift_nx;
    logic           txd_nx;

    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [3:0]     count;
    logic           overflow;
    logic           fifo_empty, fifo_full, fifo_push, fifo_pop;

    logic           io_sel;
    logic [2:0]     reg_idx;
    logic           wr_leds, wr_data, wr_status;
    logic           unused_bits;

    assign io_sel    = bus.IO_mem_addr[22];
    assign reg_idx   = bus.IO_mem_addr[4:2];
    assign wr_leds   = bus.IO_mem_wr && io_sel && (reg_idx == 3'd0);
    assign wr_data   = bus.IO_mem_wr && io_sel && (reg_idx == 3'd1);
    assign wr_status = bus.IO_mem_wr && io_sel && (reg_idx == 3'd2);
    assign unused_bits = ^{bus.IO_mem_addr[31:23], bus.IO_mem_addr[21:5],
                           bus.IO_mem_addr[1:0], bus.IO_mem_wdata[31:8]};

    // Fullness is judged on the registered count, so a same-cycle pop never rescues a push.
    assign fifo_empty = (count == 4'd0);
    assign fifo_full  = (count == CNT_FULL);
    assign fifo_push  = wr_data && !fifo_full;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (fifo_push)
            fifo_mem[wr_ptr] <= bus.IO_mem_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 4'd0;
            overflow <= 1'b0;
        end else begin
            if (fifo_push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (fifo_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({fifo_push, fifo_pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            if (wr_data && fifo_full)
                overflow <= 1'b1;
            else if (wr_status && bus.IO_mem_wdata[3])
                overflow <= 1'b0;
        end
    end

    always_comb begin
        state_nx = state;
        baud_nx  = baud;
        bit_nx   = bit_idx;
        shift_nx = shift;
        fifo_pop = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_nx = fifo_mem[rd_ptr];
                    baud_nx  = '0;
                    bit_nx   = 3'd0;
                    state_nx = START;
                end
            end
            START: begin
                if (baud == BAUD_LAST) begin
                    baud_nx  = '0;
                    state_nx = DATA;
                end else begin
                    baud_nx = baud + BW'(1);
                end
            end
            DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_nx = '0;
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                    end else begin
                        bit_nx   = bit_idx + 3'd1;
                        shift_nx = {1'b0, shift[7:1]};
                    end
                end else begin
                    baud_nx = baud + BW'(1);
                end
            end
            STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_nx = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_nx = fifo_mem[rd_ptr];
                        bit_nx   = 3'd0;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    baud_nx = baud + BW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        // TXD is registered from the next state so the start bit appears on the popping edge.
        case (state_nx)
            START:   txd_nx = 1'b0;
            DATA:    txd_nx = shift_nx[0];
            default: txd_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
            TXD     <= 1'b1;
            LEDS    <= 5'd0;
        end else begin
            state   <= state_nx;
            baud    <= baud_nx;
            bit_idx <= bit_nx;
            shift   <= shift_nx;
            TXD     <= txd_nx;
            if (wr_leds)
                LEDS <= bus.IO_mem_wdata[4:0];
        end
    end

    always_comb begin
        bus.IO_mem_rdata = 32'd0;
        if (io_sel) begin
            case (reg_idx)
                3'd0:    bus.IO_mem_rdata = {27'd0, LEDS};
                3'd2:    bus.IO_mem_rdata = {24'd0, count, overflow, fifo_full,
                                             fifo_empty, (state != IDLE)};
                default: bus.IO_mem_rdata = 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_io_bank.sv
// Directed bench for io_bank at CLKS_PER_BIT=4, FIFO_DEPTH=8; inputs change on the falling edge.
module tb_io_bank;
    localparam logic [31:0] A_LEDS   = 32'h0040_0000;
    localparam logic [31:0] A_DATA   = 32'h0040_0004;
    localparam logic [31:0] A_STATUS = 32'h0040_0008;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] LEDS;
    logic       TXD;

    io_bank_if bus ();

    io_bank #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .LEDS   (LEDS),
        .TXD    (TXD)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Call at a falling edge: the write lands on the following rising edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.IO_mem_addr  = a;
        bus.IO_mem_wdata = d;
        bus.IO_mem_wr    = 1'b1;
        @(negedge clk);
        bus.IO_mem_wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.IO_mem_addr = a;
        #1;
        d = bus.IO_mem_rdata;
    endtask

    logic [31:0] rd;
    logic [7:0]  bytes [10];
    logic [7:0]  b55;
    logic        exp_bit;
    int          slot, frame, pos;
    logic        saw_low;

    initial begin
        bus.IO_mem_addr  = 32'd0;
        bus.IO_mem_wdata = 32'd0;
        bus.IO_mem_wr    = 1'b0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        bus_read(A_STATUS, rd);
        check("reset_status", rd, 32'h0000_0002);
        check("reset_txd", {31'd0, TXD}, 32'd1);
        check("reset_leds", {27'd0, LEDS}, 32'd0);

        @(negedge clk);
        bus_write(A_LEDS, 32'h0000_003F);
        check("leds_write", {27'd0, LEDS}, 32'h1F);
        bus_read(A_LEDS, rd);
        check("leds_read", rd, 32'h0000_001F);
        @(negedge clk);
        bus_write(32'h0000_0000, 32'h0000_0000);
        check("leds_non_io", {27'd0, LEDS}, 32'h1F);
        bus_read(32'h0000_0000, rd);
        check("read_non_io", rd, 32'd0);
        @(negedge clk);
        bus_write(32'h0040_001C, 32'h0000_0012);
        check("leds_unmapped", {27'd0, LEDS}, 32'h1F);
        bus_read(32'h0040_001C, rd);
        check("read_unmapped", rd, 32'd0);
        bus_read(A_DATA, rd);
        check("read_uart_data", rd, 32'd0);

        // Single 0x55 frame: start, LSB-first data, stop, then idle.
        @(negedge clk);
        b55 = 8'h55;
        bus_write(A_DATA, 32'h0000_0055);
        check("tx55_before", {31'd0, TXD}, 32'd1);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            slot = (k - 1) / 4;
            if (slot == 0)      exp_bit = 1'b0;
            else if (slot == 9) exp_bit = 1'b1;
            else                exp_bit = b55[slot-1];
            check("tx55_txd", {31'd0, TXD}, {31'd0, exp_bit});
            if (k == 20) begin
                bus_read(A_STATUS, rd);
                check("tx55_busy_status", rd, 32'h0000_0003);
            end
        end
        @(negedge clk);
        bus_read(A_STATUS, rd);
        check("tx55_done_status", rd, 32'h0000_0002);

        // Ten back-to-back writes: nine accepted, nine frames without idle gaps.
        for (int i = 0; i < 10; i++)
            bytes[i] = 8'(i * 37 + 5);
        @(negedge clk);
        fork
            begin
                bus.IO_mem_addr  = A_DATA;
                bus.IO_mem_wdata = {24'd0, bytes[0]};
                bus.IO_mem_wr    = 1'b1;
                for (int i = 1; i < 10; i++) begin
                    @(negedge clk);
                    bus.IO_mem_wdata = {24'd0, bytes[i]};
                end
                @(negedge clk);
                bus.IO_mem_wr = 1'b0;
                bus_read(A_STATUS, rd);
                check("burst_status", rd, 32'h0000_008D);
                bus_write(A_STATUS, 32'h0000_0008);
                bus_read(A_STATUS, rd);
                check("ovf_clear_status", rd, 32'h0000_0085);
                bus_read(32'h0040_0010, rd);
                check("read_idx4", rd, 32'd0);
            end
            begin
                for (int k = 0; k <= 360; k++) begin
                    @(negedge clk);
                    if (k == 0) begin
                        exp_bit = 1'b1;
                    end else begin
                        slot  = (k - 1) / 4;
                        frame = slot / 10;
                        pos   = slot % 10;
                        if (pos == 0)      exp_bit = 1'b0;
                        else if (pos == 9) exp_bit = 1'b1;
                        else               exp_bit = bytes[frame][pos-1];
                    end
                    check("burst_txd", {31'd0, TXD}, {31'd0, exp_bit});
                end
            end
        join
        @(negedge clk);
        check("burst_idle_txd", {31'd0, TXD}, 32'd1);
        bus_read(A_STATUS, rd);
        check("burst_end_status", rd, 32'h0000_0002);

        // Reset mid-DATA with three bytes queued; a same-cycle LEDS write must lose.
        @(negedge clk);
        bus.IO_mem_addr = A_DATA;
        bus.IO_mem_wr   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.IO_mem_wdata = 32'h0000_00A0 + 32'(i);
            @(negedge clk);
        end
        bus.IO_mem_wr = 1'b0;
        repeat (5) @(negedge clk);
        bus_read(A_STATUS, rd);
        check("pre_reset_status", rd, 32'h0000_0031);
        resetn           = 1'b0;
        bus.IO_mem_addr  = A_LEDS;
        bus.IO_mem_wdata = 32'h0000_000A;
        bus.IO_mem_wr    = 1'b1;
        @(negedge clk);
        resetn        = 1'b1;
        bus.IO_mem_wr = 1'b0;
        check("rst_txd", {31'd0, TXD}, 32'd1);
        check("rst_leds", {27'd0, LEDS}, 32'd0);
        bus_read(A_STATUS, rd);
        check("rst_status", rd, 32'h0000_0002);
        saw_low = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (TXD !== 1'b1) saw_low = 1'b1;
        end
        check("rst_no_frames", {31'd0, saw_low}, 32'd0);
        bus_read(A_STATUS, rd);
        check("rst_final_status", rd, 32'h0000_0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
